// File: rtl/bus_disk_write_if.sv
// Bus-side signal bundle for bus_disk_write: RK05 write-gate/pulse inputs,
// drive status, and the word/strobe path towards the SDRAM controller.
// The slave modport is the write deserializer; master is whatever drives the bus.
interface bus_disk_write_if;
  logic        BUS_WT_GATE_L;
  logic        BUS_WT_DATA_CLK_L;
  logic        Selected_Ready;
  logic        write_protect;
  logic [15:0] data_length;
  logic        clkenbl_sector;
  logic        dram_write_enbl_buswrite;
  logic [15:0] dram_writedata;
  logic        load_address_buswrite;
  logic        write_indicator;
  logic        write_selected_ready;

  modport master (
    output BUS_WT_GATE_L, BUS_WT_DATA_CLK_L, Selected_Ready, write_protect,
           data_length, clkenbl_sector,
    input  dram_write_enbl_buswrite, dram_writedata, load_address_buswrite,
           write_indicator, write_selected_ready
  );

  modport slave (
    input  BUS_WT_GATE_L, BUS_WT_DATA_CLK_L, Selected_Ready, write_protect,
           data_length, clkenbl_sector,
    output dram_write_enbl_buswrite, dram_writedata, load_address_buswrite,
           write_indicator, write_selected_ready
  );
endinterface

// File: rtl/bus_disk_write.sv
// bus_disk_write: RK05 write path from the interface bus.
// Decodes the combined write clock/data pulse stream while the write gate is
// active, hunts for preamble + sync, then deserializes LSB-first 16-bit words
// and strobes each one to the SDRAM controller.
//
// Optional feature macro: BUS_WRITE_CRC_CHECK_EN
//   When defined, a CRC-16 (x^16+x^15+x^2+1, init 0, LSB-first) is accumulated
//   over every data bit except the final word, the final word is compared
//   against it, and a sticky crc_error output reports a mismatch.
//
// Handshake: dram_write_enbl_buswrite is a one-clock strobe; dram_writedata is
// valid only in that clock. There is no back-pressure: the SDRAM side must
// accept every strobe. load_address_buswrite is a one-clock pulse at sync.
module bus_disk_write #(
  parameter int unsigned CELL_CLKS    = 28,
  parameter int unsigned DATA_WIN_LO  = 7,
  parameter int unsigned DATA_WIN_HI  = 21,
  parameter int unsigned TIMEOUT_CLKS = 56,
  parameter int unsigned MIN_PREAMBLE = 16
) (
  input  logic                  clock,
  input  logic                  reset_L,
  bus_disk_write_if.slave       bus,
  output logic [1:0]            dbg_state
`ifdef BUS_WRITE_CRC_CHECK_EN
  , output logic                crc_error
`endif
);

  // Reject parameter sets where the bit decision falls outside the cell.
  if (DATA_WIN_LO >= DATA_WIN_HI || DATA_WIN_HI >= CELL_CLKS || TIMEOUT_CLKS > 63)
  begin : g_bad_params
    $error("bus_disk_write: inconsistent bit-window parameters");
  end

  typedef enum logic [1:0] {
    WST0 = 2'd0,  // off
    WST1 = 2'd1,  // hunt for preamble/sync
    WST2 = 2'd2,  // data words
    WST3 = 2'd3   // postamble, wait for gate release
  } wst_t;

  localparam logic [5:0] WIN_LO    = 6'(DATA_WIN_LO);
  localparam logic [5:0] WIN_HI    = 6'(DATA_WIN_HI);
  localparam logic [5:0] TMO       = 6'(TIMEOUT_CLKS);
  localparam logic [7:0] PRE_MIN   = 8'(MIN_PREAMBLE);
  localparam logic [5:0] IND_LOAD  = 6'd20;

  // Synchronizers and edge detect
  logic [3:0] gate_sync, pulse_sync;
  logic       gate_s, pulse_s, pulse_s_d, pulse_edge;

  assign gate_s  = ~gate_sync[3];
  assign pulse_s = ~pulse_sync[3];

  // Bus inputs idle high, so the chains reset to the inactive level.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      gate_sync  <= 4'hF;
      pulse_sync <= 4'hF;
      pulse_s_d  <= 1'b0;
      pulse_edge <= 1'b0;
    end else begin
      gate_sync  <= {gate_sync[2:0], bus.BUS_WT_GATE_L};
      pulse_sync <= {pulse_sync[2:0], bus.BUS_WT_DATA_CLK_L};
      pulse_s_d  <= pulse_s;
      pulse_edge <= pulse_s & ~pulse_s_d;
    end
  end

  // Bit decoder
  logic [5:0] cell_timer;
  logic       data_seen, locked;
  logic       clk_pulse, bit_strobe, bit_value;

  assign clk_pulse  = pulse_edge && (!locked || cell_timer >= WIN_HI);
  assign bit_strobe = locked && (cell_timer == WIN_HI);
  assign bit_value  = data_seen;

  // Classify each pulse edge as clock, data or glitch by its position in the cell.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      cell_timer <= 6'd0;
      data_seen  <= 1'b0;
      locked     <= 1'b0;
    end else if (clk_pulse) begin
      cell_timer <= 6'd0;
      data_seen  <= 1'b0;
      locked     <= 1'b1;
    end else begin
      if (cell_timer != 6'd63) cell_timer <= cell_timer + 6'd1;
      // Not a clock pulse here means locked and below WIN_HI.
      if (pulse_edge && cell_timer >= WIN_LO) data_seen <= 1'b1;
      if (cell_timer == TMO) locked <= 1'b0;
    end
  end

  // Word assembly state machine
  wst_t        state;
  logic [7:0]  zero_count;
  logic [3:0]  bit_count;
  logic [11:0] wordcount;
  logic [15:0] shreg, word_next, wdata_r;
  logic        wr_en_r, load_addr_r, run_ok;

  assign word_next = {bit_value, shreg[15:1]};
  assign run_ok    = gate_s && bus.Selected_Ready;
  assign dbg_state = state;

  wire unused_len_bits = ^bus.data_length[3:0];

`ifdef BUS_WRITE_CRC_CHECK_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
  endfunction
`endif

  // Sequence hunt -> data -> postamble; a gate or ready drop always wins.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state       <= WST0;
      zero_count  <= 8'd0;
      bit_count   <= 4'd0;
      wordcount   <= 12'd0;
      shreg       <= 16'd0;
      wdata_r     <= 16'd0;
      wr_en_r     <= 1'b0;
      load_addr_r <= 1'b0;
`ifdef BUS_WRITE_CRC_CHECK_EN
      crc         <= 16'd0;
      crc_error   <= 1'b0;
`endif
    end else begin
      wr_en_r     <= 1'b0;
      load_addr_r <= 1'b0;
      if (state != WST0 && !run_ok) begin
        state <= WST0;
      end else begin
        case (state)
          WST0: begin
            if (run_ok && !bus.write_protect) begin
              state      <= WST1;
              zero_count <= 8'd0;
`ifdef BUS_WRITE_CRC_CHECK_EN
              crc_error  <= 1'b0;
`endif
            end
          end
          WST1: begin
            if (bit_strobe) begin
              if (!bit_value) begin
                if (zero_count != 8'hFF) zero_count <= zero_count + 8'd1;
              end else if (zero_count >= PRE_MIN) begin
                load_addr_r <= 1'b1;
                wordcount   <= (bus.data_length[15:4] == 12'd0) ? 12'd1
                                                                : bus.data_length[15:4];
                bit_count   <= 4'd0;
                state       <= WST2;
`ifdef BUS_WRITE_CRC_CHECK_EN
                crc         <= 16'd0;
`endif
              end else begin
                zero_count <= 8'd0;
              end
            end
          end
          WST2: begin
            if (bit_strobe) begin
              shreg     <= word_next;
              bit_count <= bit_count + 4'd1;
`ifdef BUS_WRITE_CRC_CHECK_EN
              if (wordcount != 12'd1) crc <= crc_step(crc, bit_value);
`endif
              if (bit_count == 4'd15) begin
                wdata_r   <= word_next;
                wr_en_r   <= 1'b1;
                wordcount <= wordcount - 12'd1;
                if (wordcount == 12'd1) begin
                  state <= WST3;
`ifdef BUS_WRITE_CRC_CHECK_EN
                  if (word_next != crc) crc_error <= 1'b1;
`endif
                end
              end
            end
          end
          WST3: begin
            // Postamble bits are ignored; gate release is handled above.
          end
          default: state <= WST0;
        endcase
      end
    end
  end

  assign bus.dram_write_enbl_buswrite = wr_en_r;
  assign bus.dram_writedata           = wdata_r;
  assign bus.load_address_buswrite    = load_addr_r;

  // Front-panel WT indicator with sector-tick decay
  logic [5:0] ind_cnt;
  logic       ind_r, wsr_r;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      ind_cnt <= 6'd0;
      ind_r   <= 1'b0;
      wsr_r   <= 1'b0;
    end else begin
      if (run_ok) ind_cnt <= IND_LOAD;
      else if (bus.clkenbl_sector && ind_cnt != 6'd0) ind_cnt <= ind_cnt - 6'd1;
      ind_r <= (ind_cnt != 6'd0);
      wsr_r <= run_ok;
    end
  end

  assign bus.write_indicator      = ind_r;
  assign bus.write_selected_ready = wsr_r;

endmodule
